// File: rtl/io_lane_bridge_pkg.sv
// Shared width derivations for the lane/word bridge.
package io_bridge_pkg;

  function automatic int word_w(input int lane_w, input int beats);
    return lane_w * beats;
  endfunction

  function automatic int idx_w(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/io_lane_bridge_sync_fifo_reg.sv
// DEPTH x WIDTH register FIFO with push/pop/count and a synchronous flush.
module sync_fifo_reg
  import io_bridge_pkg::*;
#(
  parameter  int WIDTH = 55,
  parameter  int DEPTH = 4,
  localparam int CNT_W = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             valid,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign valid   = (count != '0);
  assign do_pop  = pop && valid;
  assign do_push = push && (count != CNT_W'(DEPTH));

  // Power-of-two DEPTH lets the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // NOTE: storage is not reset; stale entries are never visible because
  // the read port is gated by valid, which comes from the reset count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/io_lane_bridge.sv
// Bidirectional bridge: packs BEATS pad lane beats into FIFO'd words inbound,
// unpacks accelerator words into lane beats outbound.
module io_lane_bridge
  import io_bridge_pkg::*;
#(
  parameter  int LANE_W = 11,
  parameter  int BEATS  = 5,
  parameter  int DEPTH  = 4,
  localparam int WORD_W = word_w(LANE_W, BEATS),
  localparam int CNT_W  = cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_lane_valid,
  input  logic [LANE_W-1:0] in_lane_data,
  output logic              in_lane_ready,
  output logic              in_word_valid,
  output logic [WORD_W-1:0] in_word_data,
  input  logic              in_word_ready,
  output logic [CNT_W-1:0]  in_count,
  output logic              in_partial,
  output logic              overrun,
  input  logic              out_word_valid,
  input  logic [WORD_W-1:0] out_word_data,
  output logic              out_word_ready,
  output logic              out_lane_valid,
  output logic [LANE_W-1:0] out_lane_data,
  input  logic              out_lane_ready
);

  localparam int IDX_W = idx_w(BEATS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

  // ---------------- inbound packer ----------------
  logic [IDX_W-1:0]              in_idx;
  logic [BEATS-1:0][LANE_W-1:0]  in_acc;
  logic [BEATS-1:0][LANE_W-1:0]  in_word_next;
  logic                          in_is_last;
  logic                          in_take;
  logic                          fifo_push;
  logic                          fifo_pop;
  logic                          overrun_q;

  assign in_is_last = (in_idx == LAST_IDX);
  // Room is judged on the registered count only, so in_word_ready never
  // reaches in_lane_ready combinationally.
  assign in_lane_ready = !flush && (!in_is_last || (in_count < CNT_W'(DEPTH)));
  assign in_take       = in_lane_valid && in_lane_ready;
  assign fifo_push     = in_take && in_is_last;
  assign fifo_pop      = in_word_valid && in_word_ready && !flush;
  assign in_partial    = (in_idx != '0);
  assign overrun       = overrun_q;

  // NOTE: always_comb assigns a full default first so no path can infer a latch.
  always_comb begin
    in_word_next         = in_acc;
    in_word_next[in_idx] = in_lane_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      in_idx    <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (in_lane_valid && !in_lane_ready) overrun_q <= 1'b1;
      if (in_take) in_idx <= in_is_last ? '0 : in_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (in_take) in_acc[in_idx] <= in_lane_data;
  end

  sync_fifo_reg #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (fifo_push),
    .push_data (in_word_next),
    .pop       (fifo_pop),
    .pop_data  (in_word_data),
    .valid     (in_word_valid),
    .count     (in_count)
  );

  // ---------------- outbound unpacker ----------------
  logic [IDX_W-1:0]             out_idx;
  logic [BEATS-1:0][LANE_W-1:0] out_hold;
  logic                         out_busy;
  logic                         out_last;
  logic                         lane_take;
  logic                         word_take;

  assign out_last       = (out_idx == LAST_IDX);
  assign lane_take      = out_busy && out_lane_ready && !flush;
  // Accepting during the final beat handshake keeps words back-to-back.
  assign out_word_ready = !flush && (!out_busy || (out_lane_ready && out_last));
  assign word_take      = out_word_valid && out_word_ready;
  assign out_lane_valid = out_busy;
  assign out_lane_data  = out_busy ? out_hold[out_idx] : '0;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      out_busy <= 1'b0;
      out_idx  <= '0;
    end else if (word_take) begin
      out_busy <= 1'b1;
      out_idx  <= '0;
    end else if (lane_take) begin
      if (out_last) out_busy <= 1'b0;
      out_idx <= out_last ? '0 : out_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (word_take) out_hold <= out_word_data;
  end

endmodule

// File: tb/tb_io_lane_bridge.sv
// Self-checking bench: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_io_lane_bridge;

  localparam int LANE_W = 11;
  localparam int BEATS  = 5;
  localparam int DEPTH  = 4;
  localparam int WORD_W = LANE_W * BEATS;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic              in_lane_valid;
  logic [LANE_W-1:0] in_lane_data;
  logic              in_lane_ready;
  logic              in_word_valid;
  logic [WORD_W-1:0] in_word_data;
  logic              in_word_ready;
  logic [CNT_W-1:0]  in_count;
  logic              in_partial;
  logic              overrun;
  logic              out_word_valid;
  logic [WORD_W-1:0] out_word_data;
  logic              out_word_ready;
  logic              out_lane_valid;
  logic [LANE_W-1:0] out_lane_data;
  logic              out_lane_ready;

  always #5 clk = ~clk;

  io_lane_bridge #(.LANE_W(LANE_W), .BEATS(BEATS), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .in_lane_valid  (in_lane_valid),
    .in_lane_data   (in_lane_data),
    .in_lane_ready  (in_lane_ready),
    .in_word_valid  (in_word_valid),
    .in_word_data   (in_word_data),
    .in_word_ready  (in_word_ready),
    .in_count       (in_count),
    .in_partial     (in_partial),
    .overrun        (overrun),
    .out_word_valid (out_word_valid),
    .out_word_data  (out_word_data),
    .out_word_ready (out_word_ready),
    .out_lane_valid (out_lane_valid),
    .out_lane_data  (out_lane_data),
    .out_lane_ready (out_lane_ready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: beats of the word being packed, words waiting for the
  // consumer, beats still to be sent outbound, sticky overrun.
  logic [LANE_W-1:0] m_part[$];
  logic [WORD_W-1:0] m_fifo[$];
  logic [LANE_W-1:0] m_out[$];
  bit                m_ovr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [WORD_W-1:0] pack_part();
    logic [WORD_W-1:0] w;
    w = '0;
    for (int k = 0; k < BEATS; k++) w[k*LANE_W +: LANE_W] = m_part[k];
    return w;
  endfunction

  function automatic bit exp_in_ready();
    return !flush && (m_part.size() != BEATS - 1 || m_fifo.size() < DEPTH);
  endfunction

  function automatic bit exp_out_word_ready();
    return !flush && (m_out.size() == 0 || (m_out.size() == 1 && out_lane_ready));
  endfunction

  task automatic compare();
    check("in_lane_ready",  64'(in_lane_ready),  64'(exp_in_ready()));
    check("in_word_valid",  64'(in_word_valid),  64'(m_fifo.size() != 0));
    check("in_word_data",   64'(in_word_data),   64'((m_fifo.size() != 0) ? m_fifo[0] : '0));
    check("in_count",       64'(in_count),       64'(m_fifo.size()));
    check("in_partial",     64'(in_partial),     64'(m_part.size() != 0));
    check("overrun",        64'(overrun),        64'(m_ovr));
    check("out_word_ready", 64'(out_word_ready), 64'(exp_out_word_ready()));
    check("out_lane_valid", 64'(out_lane_valid), 64'(m_out.size() != 0));
    check("out_lane_data",  64'(out_lane_data),  64'((m_out.size() != 0) ? m_out[0] : '0));
  endtask

  task automatic model_step();
    bit in_rdy, w_rdy, do_pop, do_lane;
    if (!rst_n || flush) begin
      m_part.delete();
      m_fifo.delete();
      m_out.delete();
      m_ovr = 1'b0;
      return;
    end
    in_rdy  = exp_in_ready();
    w_rdy   = exp_out_word_ready();
    do_pop  = (m_fifo.size() != 0) && in_word_ready;
    do_lane = (m_out.size() != 0) && out_lane_ready;
    if (in_lane_valid && !in_rdy) m_ovr = 1'b1;
    if (do_pop) void'(m_fifo.pop_front());
    if (in_lane_valid && in_rdy) begin
      m_part.push_back(in_lane_data);
      if (m_part.size() == BEATS) begin
        m_fifo.push_back(pack_part());
        m_part.delete();
      end
    end
    if (do_lane) void'(m_out.pop_front());
    if (out_word_valid && w_rdy)
      for (int k = 0; k < BEATS; k++) m_out.push_back(out_word_data[k*LANE_W +: LANE_W]);
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic cycle();
    #1;
    if (rst_n) compare();
    model_step();
    @(negedge clk);
  endtask

  task automatic idle();
    flush          = 1'b0;
    in_lane_valid  = 1'b0;
    in_lane_data   = '0;
    in_word_ready  = 1'b0;
    out_word_valid = 1'b0;
    out_word_data  = '0;
    out_lane_ready = 1'b0;
  endtask

  task automatic reset_checks(input string tag);
    #1;
    check({tag, "_in_lane_ready"},  64'(in_lane_ready),  64'd1);
    check({tag, "_in_word_valid"},  64'(in_word_valid),  64'd0);
    check({tag, "_in_word_data"},   64'(in_word_data),   64'd0);
    check({tag, "_in_count"},       64'(in_count),       64'd0);
    check({tag, "_in_partial"},     64'(in_partial),     64'd0);
    check({tag, "_overrun"},        64'(overrun),        64'd0);
    check({tag, "_out_word_ready"}, 64'(out_word_ready), 64'd1);
    check({tag, "_out_lane_valid"}, 64'(out_lane_valid), 64'd0);
    check({tag, "_out_lane_data"},  64'(out_lane_data),  64'd0);
  endtask

  task automatic send_word(input logic [LANE_W-1:0] b0, input logic [LANE_W-1:0] b1,
                           input logic [LANE_W-1:0] b2, input logic [LANE_W-1:0] b3,
                           input logic [LANE_W-1:0] b4);
    logic [LANE_W-1:0] beats [BEATS];
    beats = '{b0, b1, b2, b3, b4};
    in_lane_valid = 1'b1;
    for (int k = 0; k < BEATS; k++) begin
      in_lane_data = beats[k];
      cycle();
    end
    in_lane_valid = 1'b0;
  endtask

  initial begin
    logic [LANE_W-1:0] exp_beat;
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    cycle();
    cycle();
    rst_n = 1'b1;
    reset_checks("reset");

    // Single inbound word, LSB beat first.
    send_word(11'h001, 11'h002, 11'h003, 11'h004, 11'h005);
    #1;
    check("single_valid", 64'(in_word_valid), 64'd1);
    check("single_data",  64'(in_word_data),  64'h5008_00C0_1001);
    check("single_model", 64'((m_fifo.size() != 0) ? m_fifo[0] : '0), 64'h5008_00C0_1001);
    check("single_count", 64'(in_count), 64'd1);
    in_word_ready = 1'b1;
    cycle();
    in_word_ready = 1'b0;

    // Fill: 4 words plus 4 beats, then the last beat stalls.
    in_lane_valid = 1'b1;
    for (int i = 0; i < 4 * BEATS + BEATS - 1; i++) begin
      in_lane_data = LANE_W'($urandom);
      cycle();
    end
    in_lane_data = LANE_W'($urandom);
    #1;
    check("full_count", 64'(in_count),      64'd4);
    check("full_stall", 64'(in_lane_ready), 64'd0);
    cycle();
    #1;
    check("full_overrun", 64'(overrun), 64'd1);
    in_word_ready = 1'b1;
    cycle();
    in_word_ready = 1'b0;
    #1;
    check("full_resume_ready", 64'(in_lane_ready), 64'd1);
    cycle();
    in_lane_valid = 1'b0;
    #1;
    check("full_refill_count", 64'(in_count),   64'd4);
    check("full_refill_part",  64'(in_partial), 64'd0);

    // Flush with a partial inbound word and an outbound word mid-beat-2.
    in_lane_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_lane_data = LANE_W'($urandom);
      cycle();
    end
    in_lane_valid  = 1'b0;
    out_word_valid = 1'b1;
    out_word_data  = {WORD_W{1'b1}} ^ WORD_W'({$urandom, $urandom});
    out_lane_ready = 1'b1;
    cycle();
    out_word_valid = 1'b0;
    cycle();
    cycle();
    #1;
    check("pre_flush_busy", 64'(out_lane_valid), 64'd1);
    flush = 1'b1;
    cycle();
    flush          = 1'b0;
    out_lane_ready = 1'b0;
    #1;
    check("flush_partial", 64'(in_partial),     64'd0);
    check("flush_count",   64'(in_count),       64'd0);
    check("flush_out",     64'(out_lane_valid), 64'd0);
    check("flush_overrun", 64'(overrun),        64'd0);
    send_word(11'h007, 11'h000, 11'h000, 11'h000, 11'h001);
    #1;
    check("post_flush_data",  64'(in_word_data), 64'h1000_0000_0007);
    check("post_flush_count", 64'(in_count),     64'd1);

    // Push and pop in the same cycle at count 2.
    send_word(11'h111, 11'h222, 11'h333, 11'h444, 11'h555);
    in_lane_valid = 1'b1;
    for (int k = 0; k < BEATS; k++) begin
      in_lane_data  = LANE_W'(11'h0A0 + k);
      in_word_ready = (k == BEATS - 1);
      cycle();
    end
    in_lane_valid = 1'b0;
    in_word_ready = 1'b0;
    #1;
    check("pushpop_count", 64'(in_count), 64'd2);
    in_word_ready = 1'b1;
    cycle();
    cycle();
    in_word_ready = 1'b0;
    #1;
    check("drain_count", 64'(in_count), 64'd0);

    // Outbound back-to-back: all-ones word then all-zeros word.
    out_lane_ready = 1'b1;
    out_word_valid = 1'b1;
    out_word_data  = {WORD_W{1'b1}};
    #1;
    check("b2b_first_ready", 64'(out_word_ready), 64'd1);
    cycle();
    out_word_data = '0;
    for (int i = 0; i < 2 * BEATS; i++) begin
      if (i == BEATS) out_word_valid = 1'b0;
      exp_beat = (i < BEATS) ? 11'h7FF : 11'h000;
      #1;
      check("b2b_valid", 64'(out_lane_valid), 64'd1);
      check("b2b_data",  64'(out_lane_data),  64'(exp_beat));
      cycle();
    end
    #1;
    check("b2b_done", 64'(out_lane_valid), 64'd0);
    out_lane_ready = 1'b0;

    // Reset for one cycle mid-stream.
    in_lane_valid = 1'b1;
    for (int i = 0; i < BEATS + 2; i++) begin
      in_lane_data = LANE_W'($urandom);
      cycle();
    end
    in_lane_valid  = 1'b0;
    out_word_valid = 1'b1;
    out_word_data  = WORD_W'({$urandom, $urandom});
    cycle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    idle();
    reset_checks("midreset");

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      in_lane_valid  = ($urandom_range(0, 9) < 7);
      in_lane_data   = LANE_W'($urandom);
      in_word_ready  = ($urandom_range(0, 9) < 4);
      out_word_valid = ($urandom_range(0, 9) < 6);
      out_word_data  = WORD_W'({$urandom, $urandom});
      out_lane_ready = ($urandom_range(0, 9) < 7);
      flush          = ($urandom_range(0, 99) == 0);
      rst_n          = ($urandom_range(0, 199) != 0);
      cycle();
    end
    idle();
    rst_n = 1'b1;
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
